// File: rtl/output_packer.sv
// Output packer: queues 3-lane result beats from the convolution controller and
// serializes them into single-channel valid/ready transfers toward the host.
module output_packer #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned DEPTH              = 4
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  in_valid,
  input  logic [31:0]           in_x,
  input  logic [31:0]           in_y,
  input  logic [31:0]           in_ch,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_x,
  output logic [31:0]           out_y,
  output logic [31:0]           out_ch,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  overflow,
  output logic                  layer_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_IDX =
    32'(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS - 1);

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  typedef struct packed {
    logic [31:0]           x;
    logic [31:0]           y;
    logic [31:0]           ch;
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
    logic [2:0]            mask;
  } entry_t;

  state_t                state_q, state_d;
  entry_t                mem [DEPTH];
  entry_t                in_entry, head, head_d;
  logic [PTR_W-1:0]      rd_q, wr_q, rd_d, wr_d;
  logic [CNT_W-1:0]      count_q, count_d, count_after_pop;
  logic [1:0]            lane_q, lane_d, adv_lane;
  logic [2:0]            in_mask;
  logic [31:0]           xfer_q, xfer_d;
  logic [31:0]           x_d, y_d, ch_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  adv_found, handshake, pop, push, drop, beat_live;
  logic                  last_d, done_d, overflow_d;

  function automatic logic [1:0] first_lane(input logic [2:0] mask);
    if (mask[0]) return 2'd0;
    if (mask[1]) return 2'd1;
    return 2'd2;
  endfunction

  // Lane k of a beat is live only if its channel exists in this layer.
  always_comb begin
    in_mask = '0;
    for (int k = 0; k < 3; k++) begin
      in_mask[k] = ({1'b0, in_ch} + 33'(k)) < 33'(OUTPUT_NB_CHANNELS);
    end
    in_entry.x     = in_x;
    in_entry.y     = in_y;
    in_entry.ch    = in_ch;
    in_entry.data0 = in_data0;
    in_entry.data1 = in_data1;
    in_entry.data2 = in_data2;
    in_entry.mask  = in_mask;
  end

  // Lane walk on the head entry and FIFO push/pop bookkeeping.
  always_comb begin
    head      = mem[rd_q];
    handshake = (state_q == SEND) && out_ready;
    adv_found = 1'b0;
    adv_lane  = lane_q;
    if (lane_q == 2'd0 && head.mask[1]) begin
      adv_found = 1'b1;
      adv_lane  = 2'd1;
    end else if (lane_q != 2'd2 && head.mask[2]) begin
      adv_found = 1'b1;
      adv_lane  = 2'd2;
    end
    pop             = handshake && !adv_found;
    beat_live       = in_valid && (in_mask != 3'b000);
    push            = beat_live && ((count_q < CNT_W'(DEPTH)) || pop);
    drop            = beat_live && !push;
    count_after_pop = count_q - CNT_W'(pop);
    count_d         = count_after_pop + CNT_W'(push);
    rd_d            = rd_q + PTR_W'(pop);
    wr_d            = wr_q + PTR_W'(push);
    // A beat landing in an otherwise empty FIFO becomes the head directly.
    head_d          = (push && count_after_pop == '0) ? in_entry : mem[rd_d];
  end

  // Next state, lane pointer, transfer counter and next registered outputs.
  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    xfer_d     = xfer_q;
    x_d        = out_x;
    y_d        = out_y;
    ch_d       = out_ch;
    data_d     = out_data;
    overflow_d = overflow | drop;
    done_d     = handshake && out_last;

    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = SEND;
          lane_d  = first_lane(head_d.mask);
        end
      end
      SEND: begin
        if (handshake) begin
          if (adv_found) begin
            lane_d = adv_lane;
          end else if (count_d == '0) begin
            state_d = EMPTY;
            lane_d  = 2'd0;
          end else begin
            lane_d = first_lane(head_d.mask);
          end
        end
      end
      default: state_d = EMPTY;
    endcase

    if (handshake) begin
      xfer_d = (xfer_q == LAST_IDX) ? '0 : xfer_q + 32'd1;
    end

    if (state_d == SEND) begin
      x_d  = head_d.x;
      y_d  = head_d.y;
      ch_d = head_d.ch + 32'(lane_d);
      case (lane_d)
        2'd0:    data_d = head_d.data0;
        2'd1:    data_d = head_d.data1;
        default: data_d = head_d.data2;
      endcase
    end
    last_d = (state_d == SEND) && (xfer_d == LAST_IDX);
  end

  assign out_valid = (state_q == SEND);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= EMPTY;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      lane_q     <= '0;
      xfer_q     <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_ch     <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
      overflow   <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      lane_q     <= lane_d;
      xfer_q     <= xfer_d;
      out_x      <= x_d;
      out_y      <= y_d;
      out_ch     <= ch_d;
      out_data   <= data_d;
      out_last   <= last_d;
      overflow   <= overflow_d;
      layer_done <= done_d;
    end
  end

endmodule

// File: tb/tb_output_packer.sv
// Self-checking bench for output_packer: directed scenarios plus randomized
// traffic scored against a lane-queue reference model.
module tb_output_packer;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NCH   = 64;

  logic          clk;
  logic          rst_in, in_valid, out_ready;
  logic [31:0]   in_x, in_y, in_ch;
  logic [DW-1:0] in_data0, in_data1, in_data2;
  logic          out_valid, out_last, overflow, layer_done;
  logic [31:0]   out_x, out_y, out_ch;
  logic [DW-1:0] out_data;

  logic          l_rst, l_in_valid, l_ready;
  logic [31:0]   l_in_x, l_in_y, l_in_ch;
  logic [DW-1:0] l_d0, l_d1, l_d2;
  logic          l_valid, l_last, l_ovf, l_done;
  logic [31:0]   l_x, l_y, l_ch;
  logic [DW-1:0] l_data;

  int n_cmp = 0;
  int n_err = 0;

  output_packer #(
    .FEATURE_MAP_WIDTH(1024), .FEATURE_MAP_HEIGHT(1024), .OUTPUT_NB_CHANNELS(NCH),
    .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_in(rst_in), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_ch(out_ch), .out_data(out_data),
    .out_last(out_last), .overflow(overflow), .layer_done(layer_done)
  );

  output_packer #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(3),
    .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) l_dut (
    .clk(clk), .rst_in(l_rst), .in_valid(l_in_valid),
    .in_x(l_in_x), .in_y(l_in_y), .in_ch(l_in_ch),
    .in_data0(l_d0), .in_data1(l_d1), .in_data2(l_d2),
    .out_valid(l_valid), .out_ready(l_ready),
    .out_x(l_x), .out_y(l_y), .out_ch(l_ch), .out_data(l_data),
    .out_last(l_last), .overflow(l_ovf), .layer_done(l_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  // Reference model: queue of pending single-channel transfers, beats counted by beat_end.
  typedef struct {
    logic [31:0] x, y, ch, data;
    bit          beat_end;
  } xfer_t;

  xfer_t mq[$];
  int    m_beats = 0;
  bit    m_ovf   = 1'b0;

  always @(posedge clk) begin : model
    bit    hs, pop_beat, accept;
    xfer_t lanes[$];
    xfer_t t;
    if (rst_in) begin
      mq.delete();
      m_beats = 0;
      m_ovf   = 1'b0;
    end else begin
      hs       = (mq.size() > 0) && out_ready;
      pop_beat = hs && mq[0].beat_end;
      lanes.delete();
      if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          if (longint'(in_ch) + longint'(k) < longint'(NCH)) begin
            t.x        = in_x;
            t.y        = in_y;
            t.ch       = in_ch + 32'(k);
            t.data     = (k == 0) ? in_data0 : (k == 1) ? in_data1 : in_data2;
            t.beat_end = 1'b0;
            lanes.push_back(t);
          end
        end
      end
      accept = (lanes.size() > 0) && ((m_beats < int'(DEPTH)) || pop_beat);
      if (lanes.size() > 0 && !accept) m_ovf = 1'b1;
      if (hs) void'(mq.pop_front());
      if (pop_beat) m_beats--;
      if (accept) begin
        lanes[lanes.size() - 1].beat_end = 1'b1;
        foreach (lanes[i]) mq.push_back(lanes[i]);
        m_beats++;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ch,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    in_valid = 1'b1; in_x = x; in_y = y; in_ch = ch;
    in_data0 = d0; in_data1 = d1; in_data2 = d2;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %0b want 0", out_last); end
    n_cmp++; if (layer_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", layer_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    n_cmp++; if ({out_x, out_y, out_ch, out_data} !== '0) begin n_err++;
      $display("FAIL reset_tags: got x=%0h y=%0h ch=%0h d=%0h want all 0", out_x, out_y, out_ch, out_data); end
    n_cmp++; if ({l_valid, l_last, l_done, l_ovf} !== 4'b0) begin n_err++;
      $display("FAIL reset_layer_dut: got v/l/d/o=%b want 0000", {l_valid, l_last, l_done, l_ovf}); end
  endtask

  task automatic test_single_beat();
    apply_reset();
    out_ready = 1'b1;
    @(negedge clk);
    drive_beat(32'd5, 32'd7, 32'd0, 32'd10, 32'd20, 32'd30);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_same_cycle: got valid %0b want 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %0b want 1", k, out_valid); end
      n_cmp++; if (out_ch !== 32'(k) || out_data !== 32'(10 * (k + 1))) begin n_err++;
        $display("FAIL single_lane[%0d]: got ch=%0d d=%0d want ch=%0d d=%0d", k, out_ch, out_data, k, 10 * (k + 1)); end
      n_cmp++; if (out_x !== 32'd5 || out_y !== 32'd7) begin n_err++;
        $display("FAIL single_tag[%0d]: got x=%0d y=%0d want 5 7", k, out_x, out_y); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_after: got valid %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0]   bx, by;
    logic [DW-1:0] bd [3];
    apply_reset();
    bx = $urandom; by = $urandom;
    for (int k = 0; k < 3; k++) bd[k] = $urandom;
    @(negedge clk);
    drive_beat(bx, by, 32'd0, bd[0], bd[1], bd[2]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== 32'd0 || out_data !== bd[0] || out_x !== bx) begin n_err++;
        $display("FAIL bp_hold[%0d]: got v=%0b ch=%0d d=%0h x=%0h want 1 0 %0h %0h", i, out_valid, out_ch, out_data, out_x, bd[0], bx); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_ch !== 32'(k) || out_data !== bd[k] || out_y !== by) begin n_err++;
        $display("FAIL bp_release[%0d]: got v=%0b ch=%0d d=%0h y=%0h want 1 %0d %0h %0h", k, out_valid, out_ch, out_data, out_y, k, bd[k], by); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_after: got valid %0b want 0", out_valid); end
  endtask

  task automatic test_channel_edge();
    logic [DW-1:0] d0;
    apply_reset();
    out_ready = 1'b1;
    d0 = $urandom;
    @(negedge clk);
    drive_beat(32'd1, 32'd2, 32'd63, d0, $urandom, $urandom);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 32'd63 || out_data !== d0) begin n_err++;
      $display("FAIL edge63: got v=%0b ch=%0d d=%0h want 1 63 %0h", out_valid, out_ch, out_data, d0); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL edge63_single: got valid %0b want 0", out_valid); end
    drive_beat(32'd3, 32'd4, 32'd66, $urandom, $urandom, $urandom);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin n_err++;
        $display("FAIL edge66[%0d]: got v=%0b ovf=%0b want 0 0", i, out_valid, overflow); end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    int n;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %0b want 0", overflow); end
      end
      drive_beat(32'(i), 32'd0, 32'd0, 32'(100 * i), 32'(100 * i + 1), 32'(100 * i + 2));
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", overflow); end
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        n_cmp++; if (out_x !== 32'(n / 3) || out_ch !== 32'(n % 3) || out_data !== 32'(100 * (n / 3) + n % 3)) begin n_err++;
          $display("FAIL ovf_drain[%0d]: got x=%0d ch=%0d d=%0d want %0d %0d %0d", n, out_x, out_ch, out_data, n / 3, n % 3, 100 * (n / 3) + n % 3); end
        n++;
      end
      @(negedge clk);
    end
    n_cmp++; if (n != 12) begin n_err++; $display("FAIL ovf_count: got %0d transfers want 12", n); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_full_pop();
    int n, ex;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_beat(32'(i), 32'd1, 32'd0, 32'(i), 32'(i), 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_ch !== 32'd2) begin n_err++;
      $display("FAIL fullpop_head: got v=%0b ch=%0d want 1 2", out_valid, out_ch); end
    drive_beat(32'd99, 32'd1, 32'd0, 32'd99, 32'd99, 32'd99);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpop_ovf: got %0b want 0", overflow); end
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        ex = (n / 3 < 3) ? n / 3 + 1 : 99;
        n_cmp++; if (out_x !== 32'(ex) || out_ch !== 32'(n % 3)) begin n_err++;
          $display("FAIL fullpop_drain[%0d]: got x=%0d ch=%0d want %0d %0d", n, out_x, out_ch, ex, n % 3); end
        n++;
      end
      @(negedge clk);
    end
    n_cmp++; if (n != 12) begin n_err++; $display("FAIL fullpop_count: got %0d transfers want 12", n); end
  endtask

  task automatic test_layer_end();
    int            n, dones;
    bit            prev_last;
    logic [DW-1:0] dat [4][3];
    n = 0; dones = 0; prev_last = 1'b0;
    l_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      n_cmp++; if (l_done !== prev_last) begin n_err++; $display("FAIL layer_done[c%0d]: got %0b want %0b", c, l_done, prev_last); end
      if (l_done) dones++;
      prev_last = 1'b0;
      if (l_valid) begin
        n++;
        n_cmp++; if (l_last !== (n == 12)) begin n_err++; $display("FAIL layer_last[%0d]: got %0b want %0b", n, l_last, n == 12); end
        n_cmp++; if (l_ch !== 32'((n - 1) % 3) || l_data !== dat[(n - 1) / 3][(n - 1) % 3] || l_x !== 32'(((n - 1) / 3) % 2)) begin n_err++;
          $display("FAIL layer_xfer[%0d]: got ch=%0d d=%0h x=%0d want %0d %0h %0d", n, l_ch, l_data, l_x,
                   (n - 1) % 3, dat[(n - 1) / 3][(n - 1) % 3], ((n - 1) / 3) % 2); end
        prev_last = (n == 12);
      end
      if (c < 4) begin
        for (int k = 0; k < 3; k++) dat[c][k] = $urandom;
        l_in_valid = 1'b1; l_in_x = 32'(c % 2); l_in_y = 32'(c / 2); l_in_ch = 32'd0;
        l_d0 = dat[c][0]; l_d1 = dat[c][1]; l_d2 = dat[c][2];
      end else begin
        l_in_valid = 1'b0;
      end
    end
    n_cmp++; if (n != 12 || dones != 1) begin n_err++; $display("FAIL layer_totals: got %0d xfers %0d pulses want 12 1", n, dones); end
  endtask

  task automatic test_reset_mid_drain();
    l_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        l_in_valid = 1'b1; l_in_x = 32'(c); l_in_y = 32'd0; l_in_ch = 32'd0;
        l_d0 = $urandom; l_d1 = $urandom; l_d2 = $urandom;
      end else begin
        l_in_valid = 1'b0;
      end
    end
    n_cmp++; if (l_valid !== 1'b1) begin n_err++; $display("FAIL mid_busy: got valid %0b want 1", l_valid); end
    l_rst = 1'b1;
    @(negedge clk);
    l_rst = 1'b0;
    n_cmp++; if ({l_valid, l_last, l_done, l_ovf} !== 4'b0) begin n_err++;
      $display("FAIL mid_reset: got v/l/d/o=%b want 0000", {l_valid, l_last, l_done, l_ovf}); end
    test_layer_end();
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++;
        $display("FAIL rand_valid[c%0d]: got %0b want %0b", c, out_valid, mq.size() > 0); end
      if (mq.size() > 0) begin
        n_cmp++; if (out_x !== mq[0].x || out_y !== mq[0].y || out_ch !== mq[0].ch || out_data !== mq[0].data) begin n_err++;
          $display("FAIL rand_xfer[c%0d]: got x=%0h y=%0h ch=%0d d=%0h want %0h %0h %0d %0h", c, out_x, out_y, out_ch, out_data,
                   mq[0].x, mq[0].y, mq[0].ch, mq[0].data); end
      end
      n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_ovf[c%0d]: got %0b want %0b", c, overflow, m_ovf); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rand_last[c%0d]: got %0b want 0", c, out_last); end
      if ($urandom_range(0, 99) < 40) begin
        drive_beat($urandom, $urandom, 32'($urandom_range(0, 70)), $urandom, $urandom, $urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (c % 150 < 12) ? 1'b0 : ($urandom_range(0, 99) < 80);
    end
  endtask

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_ch = '0; in_data0 = '0; in_data1 = '0; in_data2 = '0;
    l_rst = 1'b1; l_in_valid = 1'b0; l_ready = 1'b0;
    l_in_x = '0; l_in_y = '0; l_in_ch = '0; l_d0 = '0; l_d1 = '0; l_d2 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_in = 1'b0;
    l_rst  = 1'b0;
    test_single_beat();
    test_backpressure();
    test_channel_edge();
    test_overflow();
    test_full_pop();
    test_layer_end();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
